// File: rtl/attack_round_ctrl.sv
// rtl/attack_round_ctrl.sv - clocked attack-round controller: shot map, shot/ship counters, RGB and LED-matrix drive
module attack_round_ctrl #(
   parameter int COLUMNS     = 5,
   parameter int ROWS        = 7,
   parameter int COORD_WIDTH = 3,
   parameter int MAX_SHOTS   = 16,
   parameter int DATA_WIDTH  = COLUMNS*ROWS
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [DATA_WIDTH-1:0]             selected_map,
   input  logic [COORD_WIDTH-1:0]            x_coord_code,
   input  logic [COORD_WIDTH-1:0]            y_coord_code,
   input  logic                              confirm_attack_n,
   output logic [DATA_WIDTH-1:0]             matriz_data,
   output logic [1:0]                        ledRgb,
   output logic [$clog2(MAX_SHOTS+1)-1:0]    shots_left,
   output logic [$clog2(DATA_WIDTH+1)-1:0]   ships_left,
   output logic                              game_won,
   output logic                              game_lost,
   output logic                              armed
);

   localparam int SW = $clog2(MAX_SHOTS+1);
   localparam int KW = $clog2(DATA_WIDTH+1);
   localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, ARMED, WON, LOST} state_t;

   state_t                state_q, state_n;
   logic [DATA_WIDTH-1:0] ship_q, ship_n;
   logic [DATA_WIDTH-1:0] shot_q, shot_n;
   logic [DATA_WIDTH-1:0] matriz_q, matriz_n;
   logic [1:0]            led_q, led_n;
   logic [SW-1:0]         shots_q, shots_n;
   logic [KW-1:0]         ships_q, ships_n;
   logic                  confirm_q;
   logic                  attack_evt;
   logic                  in_range;
   logic [IW-1:0]         cell_idx;
   logic [KW-1:0]         pop;

   // Falling edge of the debounced button; holding it low yields one event.
   assign attack_evt = confirm_q & ~confirm_attack_n;
   assign in_range   = (int'(x_coord_code) < COLUMNS) && (int'(y_coord_code) < ROWS);

   always_comb begin
      state_n  = state_q;
      ship_n   = ship_q;
      shot_n   = shot_q;
      led_n    = led_q;
      shots_n  = shots_q;
      ships_n  = ships_q;
      matriz_n = '1;
      cell_idx = IW'(x_coord_code) * IW'(ROWS) + IW'(y_coord_code);
      pop      = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         pop = pop + KW'(ship_q[i]);
      end

      if (start) begin
         state_n = LOAD;
         ship_n  = selected_map;
         shot_n  = '0;
         led_n   = 2'b00;
      end else begin
         case (state_q)
            LOAD: begin
               shots_n = SW'(MAX_SHOTS);
               ships_n = pop;
               state_n = (pop == '0) ? WON : ARMED;
            end
            ARMED: begin
               if (attack_evt && in_range) begin
                  if (shot_q[cell_idx]) begin
                     led_n = 2'b11;
                  end else begin
                     shot_n[cell_idx] = 1'b1;
                     shots_n          = shots_q - SW'(1);
                     if (ship_q[cell_idx]) begin
                        ships_n = ships_q - KW'(1);
                        led_n   = 2'b10;
                     end else begin
                        led_n   = 2'b01;
                     end
                     // A final shot that also sinks the last ship counts as a win.
                     if (ships_n == '0) begin
                        state_n = WON;
                     end else if (shots_n == '0) begin
                        state_n = LOST;
                     end
                  end
               end
            end
            default: ;
         endcase
      end

      case (state_n)
         LOAD, ARMED: matriz_n = ~shot_n;
         WON, LOST:   matriz_n = ~(shot_n | ship_n);
         default:     matriz_n = '1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         ship_q    <= '0;
         shot_q    <= '0;
         matriz_q  <= '1;
         led_q     <= 2'b00;
         shots_q   <= '0;
         ships_q   <= '0;
         confirm_q <= 1'b1;
      end else begin
         state_q   <= state_n;
         ship_q    <= ship_n;
         shot_q    <= shot_n;
         matriz_q  <= matriz_n;
         led_q     <= led_n;
         shots_q   <= shots_n;
         ships_q   <= ships_n;
         confirm_q <= confirm_attack_n;
      end
   end

   assign matriz_data = matriz_q;
   assign ledRgb      = led_q;
   assign shots_left  = shots_q;
   assign ships_left  = ships_q;
   assign game_won    = (state_q == WON);
   assign game_lost   = (state_q == LOST);
   assign armed       = (state_q == ARMED);

endmodule

// File: tb/tb_attack_round_ctrl.sv
// tb/tb_attack_round_ctrl.sv - directed self-checking bench for attack_round_ctrl
module tb_attack_round_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [34:0] selected_map;
   logic [2:0]  x_coord_code;
   logic [2:0]  y_coord_code;
   logic        confirm_attack_n;
   logic [34:0] matriz_data;
   logic [1:0]  ledRgb;
   logic [2:0]  shots_left;
   logic [5:0]  ships_left;
   logic        game_won;
   logic        game_lost;
   logic        armed;

   int checks = 0;
   int errors = 0;
   logic [34:0] exp_m;

   attack_round_ctrl #(.MAX_SHOTS(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .selected_map     (selected_map),
      .x_coord_code     (x_coord_code),
      .y_coord_code     (y_coord_code),
      .confirm_attack_n (confirm_attack_n),
      .matriz_data      (matriz_data),
      .ledRgb           (ledRgb),
      .shots_left       (shots_left),
      .ships_left       (ships_left),
      .game_won         (game_won),
      .game_lost        (game_lost),
      .armed            (armed)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic attack(input int x, input int y);
      x_coord_code     = 3'(x);
      y_coord_code     = 3'(y);
      confirm_attack_n = 1'b0;
      tick();
      confirm_attack_n = 1'b1;
      tick();
   endtask

   task automatic start_round(input logic [34:0] map);
      selected_map = map;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      tick();
   endtask

   initial begin
      reset            = 1'b0;
      start            = 1'b0;
      selected_map     = '0;
      x_coord_code     = '0;
      y_coord_code     = '0;
      confirm_attack_n = 1'b1;
      tick();
      tick();
      check("rst_armed", armed, 0);
      check("rst_led", ledRgb, 0);
      check("rst_shots", shots_left, 0);
      check("rst_ships", ships_left, 0);
      check("rst_won", game_won, 0);
      check("rst_lost", game_lost, 0);
      check("rst_matriz", matriz_data, 35'h7_FFFF_FFFF);
      reset = 1'b1;
      tick();

      start_round(35'h101);
      check("load_armed", armed, 1);
      check("load_shots", shots_left, 4);
      check("load_ships", ships_left, 2);
      check("load_matriz", matriz_data, 35'h7_FFFF_FFFF);

      attack(0, 0);
      check("hit_led", ledRgb, 2'b10);
      check("hit_shots", shots_left, 3);
      check("hit_ships", ships_left, 1);
      check("hit_matriz", matriz_data, 35'h7_FFFF_FFFE);

      attack(0, 0);
      check("rep_led", ledRgb, 2'b11);
      check("rep_shots", shots_left, 3);
      check("rep_ships", ships_left, 1);

      attack(4, 6);
      check("miss_led", ledRgb, 2'b01);
      check("miss_shots", shots_left, 2);
      exp_m = '1; exp_m[0] = 1'b0; exp_m[34] = 1'b0;
      check("miss_matriz", matriz_data, exp_m);

      attack(5, 0);
      check("oorx_led", ledRgb, 2'b01);
      check("oorx_shots", shots_left, 2);
      check("oorx_matriz", matriz_data, exp_m);
      attack(0, 7);
      check("oory_led", ledRgb, 2'b01);
      check("oory_shots", shots_left, 2);
      check("oory_armed", armed, 1);

      attack(2, 0);
      check("miss2_shots", shots_left, 1);
      attack(1, 1);
      check("win_won", game_won, 1);
      check("win_lost", game_lost, 0);
      check("win_shots", shots_left, 0);
      check("win_ships", ships_left, 0);
      check("win_led", ledRgb, 2'b10);
      exp_m = '1; exp_m[0] = 1'b0; exp_m[8] = 1'b0; exp_m[14] = 1'b0; exp_m[34] = 1'b0;
      check("win_matriz", matriz_data, exp_m);
      attack(3, 3);
      check("won_frozen_led", ledRgb, 2'b10);
      check("won_frozen_won", game_won, 1);

      start_round(35'h101);
      check("r2_armed", armed, 1);
      check("r2_won", game_won, 0);
      check("r2_led", ledRgb, 2'b00);
      check("r2_shots", shots_left, 4);
      x_coord_code     = 3'd2;
      y_coord_code     = 3'd2;
      confirm_attack_n = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      confirm_attack_n = 1'b1;
      tick();
      check("hold_shots", shots_left, 3);
      attack(3, 0);
      attack(3, 1);
      attack(3, 2);
      check("loss_lost", game_lost, 1);
      check("loss_won", game_won, 0);
      check("loss_shots", shots_left, 0);
      check("loss_ships", ships_left, 2);
      exp_m = '1; exp_m[0] = 1'b0; exp_m[8] = 1'b0; exp_m[16] = 1'b0;
      exp_m[21] = 1'b0; exp_m[22] = 1'b0; exp_m[23] = 1'b0;
      check("loss_matriz", matriz_data, exp_m);

      selected_map     = 35'h101;
      x_coord_code     = 3'd0;
      y_coord_code     = 3'd0;
      start            = 1'b1;
      confirm_attack_n = 1'b0;
      tick();
      start            = 1'b0;
      confirm_attack_n = 1'b1;
      tick();
      check("sa_armed", armed, 1);
      check("sa_shots", shots_left, 4);
      check("sa_ships", ships_left, 2);
      check("sa_matriz", matriz_data, 35'h7_FFFF_FFFF);
      check("sa_led", ledRgb, 2'b00);

      attack(1, 1);
      check("mid_ships", ships_left, 1);
      #2;
      reset = 1'b0;
      #1;
      check("arst_armed", armed, 0);
      check("arst_led", ledRgb, 0);
      check("arst_shots", shots_left, 0);
      check("arst_ships", ships_left, 0);
      check("arst_matriz", matriz_data, 35'h7_FFFF_FFFF);
      tick();
      reset = 1'b1;
      tick();
      check("idle_armed", armed, 0);

      selected_map = '0;
      start        = 1'b1;
      tick();
      start        = 1'b0;
      check("empty_load_won", game_won, 0);
      tick();
      check("empty_won", game_won, 1);
      check("empty_ships", ships_left, 0);
      check("empty_shots", shots_left, 4);
      check("empty_armed", armed, 0);
      check("empty_matriz", matriz_data, 35'h7_FFFF_FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
